// File: rtl/set_assoc_data_cache.sv
// Write-back, write-allocate N-way set-associative data cache with FIFO replacement.
// Misses stall the core while whole lines move over a line-wide memory handshake.
module set_assoc_data_cache #(
    parameter int unsigned LINE_ADDR_LEN = 3,
    parameter int unsigned SET_ADDR_LEN  = 3,
    parameter int unsigned WAY_CNT       = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               rd_req,
    input  logic                               wr_req,
    input  logic [29:0]                        addr,
    input  logic [3:0]                         byte_en,
    input  logic [31:0]                        wr_data,
    output logic [31:0]                        rd_data,
    output logic                               miss,
    output logic                               mem_req,
    output logic                               mem_we,
    output logic [29-LINE_ADDR_LEN:0]          mem_addr,
    output logic [32*(2**LINE_ADDR_LEN)-1:0]   mem_wdata,
    input  logic [32*(2**LINE_ADDR_LEN)-1:0]   mem_rdata,
    input  logic                               mem_gnt,
    output logic [31:0]                        hit_cnt,
    output logic [31:0]                        miss_cnt
);

    localparam int unsigned TAG_ADDR_LEN = 30 - LINE_ADDR_LEN - SET_ADDR_LEN;
    localparam int unsigned LINE_WORDS   = 2 ** LINE_ADDR_LEN;
    localparam int unsigned SET_CNT      = 2 ** SET_ADDR_LEN;
    localparam int unsigned LINE_W       = 32 * LINE_WORDS;
    localparam int unsigned WAY_W        = (WAY_CNT > 1) ? $clog2(WAY_CNT) : 1;

    typedef enum logic [1:0] {StIdle, StWb, StFill, StInstall} state_e;

    logic [TAG_ADDR_LEN-1:0]  req_tag;
    logic [SET_ADDR_LEN-1:0]  req_set;
    logic [LINE_ADDR_LEN-1:0] req_word;
    logic                     req;

    assign req_word = addr[LINE_ADDR_LEN-1:0];
    assign req_set  = addr[LINE_ADDR_LEN+SET_ADDR_LEN-1:LINE_ADDR_LEN];
    assign req_tag  = addr[29:LINE_ADDR_LEN+SET_ADDR_LEN];
    assign req      = rd_req | wr_req;

    logic [SET_CNT-1:0]      valid_q [WAY_CNT];
    logic [SET_CNT-1:0]      dirty_q [WAY_CNT];
    logic [TAG_ADDR_LEN-1:0] tag_q   [WAY_CNT][SET_CNT];
    logic [LINE_W-1:0]       line_q  [WAY_CNT][SET_CNT];

    state_e                  state_q, state_d;
    logic                    mem_req_q, mem_we_q, replay_q;
    logic [31:0]             hit_cnt_q, miss_cnt_q;
    logic [TAG_ADDR_LEN-1:0] miss_tag_q, victim_tag_q;
    logic [SET_ADDR_LEN-1:0] miss_set_q;
    logic [WAY_W-1:0]        victim_q, cur_ptr;
    logic [LINE_W-1:0]       fill_line_q;

    logic [WAY_CNT-1:0]      way_match;
    logic                    hit, start_miss, gnt_ok;
    logic                    vic_valid, vic_dirty;
    logic [TAG_ADDR_LEN-1:0] vic_tag;
    logic [LINE_W-1:0]       hit_line, wb_line;

    always_comb begin
        way_match = '0;
        for (int w = 0; w < WAY_CNT; w++) begin
            way_match[w] = valid_q[w][req_set] && (tag_q[w][req_set] == req_tag);
        end
    end

    // Hits are only honoured in idle; a pending refill owns the arrays otherwise.
    assign hit    = req && (|way_match) && (state_q == StIdle);
    assign miss   = (req && !hit) || (state_q != StIdle);
    assign gnt_ok = mem_req_q && mem_gnt;

    always_comb begin
        vic_valid = 1'b0;
        vic_dirty = 1'b0;
        vic_tag   = '0;
        hit_line  = '0;
        wb_line   = '0;
        for (int w = 0; w < WAY_CNT; w++) begin
            if (WAY_W'(w) == cur_ptr) begin
                vic_valid = valid_q[w][req_set];
                vic_dirty = dirty_q[w][req_set];
                vic_tag   = tag_q[w][req_set];
            end
            if (WAY_W'(w) == victim_q) wb_line = line_q[w][miss_set_q];
            if (way_match[w]) hit_line = line_q[w][req_set];
        end
    end

    always_comb begin
        rd_data = '0;
        if (hit && rd_req) begin
            for (int i = 0; i < LINE_WORDS; i++) begin
                if (LINE_ADDR_LEN'(i) == req_word) rd_data = hit_line[i*32 +: 32];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        start_miss = 1'b0;
        case (state_q)
            StIdle: begin
                if (req && !(|way_match)) begin
                    start_miss = 1'b1;
                    state_d    = (vic_valid && vic_dirty) ? StWb : StFill;
                end
            end
            StWb:      if (gnt_ok) state_d = StFill;
            StFill:    if (gnt_ok) state_d = StInstall;
            StInstall: state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            replay_q   <= 1'b0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            // Request stays high straight through a write-back into its refill.
            mem_req_q <= (state_d == StWb) || (state_d == StFill);
            mem_we_q  <= (state_d == StWb);
            replay_q  <= (state_q == StInstall);
            if (start_miss) miss_cnt_q <= miss_cnt_q + 32'd1;
            if (hit && !replay_q) hit_cnt_q <= hit_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (start_miss) begin
            miss_tag_q   <= req_tag;
            miss_set_q   <= req_set;
            victim_q     <= cur_ptr;
            victim_tag_q <= vic_tag;
        end
        if ((state_q == StFill) && gnt_ok) fill_line_q <= mem_rdata;
    end

    if (WAY_CNT > 1) begin : g_fifo
        logic [WAY_W-1:0] fifo_ptr_q [SET_CNT];

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int s = 0; s < SET_CNT; s++) fifo_ptr_q[s] <= '0;
            end else if (state_q == StInstall) begin
                fifo_ptr_q[miss_set_q] <= fifo_ptr_q[miss_set_q] + WAY_W'(1);
            end
        end

        assign cur_ptr = fifo_ptr_q[req_set];
    end else begin : g_no_fifo
        assign cur_ptr = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int w = 0; w < WAY_CNT; w++) begin
                valid_q[w] <= '0;
                dirty_q[w] <= '0;
            end
        end else begin
            for (int w = 0; w < WAY_CNT; w++) begin
                if ((state_q == StInstall) && (WAY_W'(w) == victim_q)) begin
                    valid_q[w][miss_set_q] <= 1'b1;
                    dirty_q[w][miss_set_q] <= 1'b0;
                end else if (hit && wr_req && way_match[w]) begin
                    dirty_q[w][req_set] <= 1'b1;
                end
            end
        end
    end

    // Tag and data contents carry no reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int w = 0; w < WAY_CNT; w++) begin
                if ((state_q == StInstall) && (WAY_W'(w) == victim_q)) begin
                    tag_q[w][miss_set_q]  <= miss_tag_q;
                    line_q[w][miss_set_q] <= fill_line_q;
                end else if (hit && wr_req && way_match[w]) begin
                    for (int i = 0; i < LINE_WORDS; i++) begin
                        for (int b = 0; b < 4; b++) begin
                            if ((LINE_ADDR_LEN'(i) == req_word) && byte_en[b]) begin
                                line_q[w][req_set][i*32+b*8 +: 8] <= wr_data[b*8 +: 8];
                            end
                        end
                    end
                end
            end
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = (state_q == StWb) ? {victim_tag_q, miss_set_q} : {miss_tag_q, miss_set_q};
    assign mem_wdata = wb_line;
    assign hit_cnt   = hit_cnt_q;
    assign miss_cnt  = miss_cnt_q;

endmodule

// File: tb/tb_set_assoc_data_cache.sv
// Directed bench: default 4-way cache plus a direct-mapped (1-way, 4-set) instance.
// Memory grants are issued by the access task after a chosen number of request cycles.
module tb_set_assoc_data_cache;

    logic         clk, rst, sel;
    logic         rd_req, wr_req, mem_gnt;
    logic [29:0]  addr;
    logic [3:0]   byte_en;
    logic [31:0]  wr_data;
    logic [255:0] mem_rdata;

    logic [31:0]  a_rd_data, b_rd_data, a_hit_cnt, b_hit_cnt, a_miss_cnt, b_miss_cnt;
    logic         a_miss, b_miss, a_mem_req, b_mem_req, a_mem_we, b_mem_we;
    logic [26:0]  a_mem_addr, b_mem_addr;
    logic [255:0] a_mem_wdata, b_mem_wdata;

    logic         a_rd, a_wr, a_gnt, b_rd, b_wr, b_gnt;
    logic [31:0]  rd_data_w, hit_cnt_w, miss_cnt_w;
    logic         miss_w, mem_req_w, mem_we_w;
    logic [26:0]  mem_addr_w;
    logic [255:0] mem_wdata_w;

    assign a_rd = rd_req & ~sel;
    assign a_wr = wr_req & ~sel;
    assign a_gnt = mem_gnt & ~sel;
    assign b_rd = rd_req & sel;
    assign b_wr = wr_req & sel;
    assign b_gnt = mem_gnt & sel;
    assign rd_data_w   = sel ? b_rd_data : a_rd_data;
    assign hit_cnt_w   = sel ? b_hit_cnt : a_hit_cnt;
    assign miss_cnt_w  = sel ? b_miss_cnt : a_miss_cnt;
    assign miss_w      = sel ? b_miss : a_miss;
    assign mem_req_w   = sel ? b_mem_req : a_mem_req;
    assign mem_we_w    = sel ? b_mem_we : a_mem_we;
    assign mem_addr_w  = sel ? b_mem_addr : a_mem_addr;
    assign mem_wdata_w = sel ? b_mem_wdata : a_mem_wdata;

    set_assoc_data_cache u_dut (
        .clk(clk), .rst(rst), .rd_req(a_rd), .wr_req(a_wr), .addr(addr), .byte_en(byte_en),
        .wr_data(wr_data), .rd_data(a_rd_data), .miss(a_miss), .mem_req(a_mem_req),
        .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
        .mem_rdata(mem_rdata), .mem_gnt(a_gnt), .hit_cnt(a_hit_cnt), .miss_cnt(a_miss_cnt)
    );

    set_assoc_data_cache #(.LINE_ADDR_LEN(3), .SET_ADDR_LEN(2), .WAY_CNT(1)) u_dm (
        .clk(clk), .rst(rst), .rd_req(b_rd), .wr_req(b_wr), .addr(addr), .byte_en(byte_en),
        .wr_data(wr_data), .rd_data(b_rd_data), .miss(b_miss), .mem_req(b_mem_req),
        .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_rdata(mem_rdata), .mem_gnt(b_gnt), .hit_cnt(b_hit_cnt), .miss_cnt(b_miss_cnt)
    );

    always #5 clk = ~clk;

    int           n_vec, n_err;
    int           stall, wb_seen, fill_seen;
    logic         req_at_detect;
    logic [26:0]  wb_addr, fill_addr;
    logic [255:0] wb_data, ln;
    logic [31:0]  rdv;
    logic [255:0] mem_model [int unsigned];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] make_line(input int unsigned la);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = (la << 8) | i;
        return l;
    endfunction

    function automatic logic [255:0] line_of(input int unsigned la);
        if (mem_model.exists(la)) return mem_model[la];
        return make_line(la);
    endfunction

    // One CPU access held until miss drops; memory grants after g request cycles.
    task automatic access(input bit is_wr, input logic [29:0] a, input logic [3:0] be,
                          input logic [31:0] wd, input int g);
        int cnt;
        @(negedge clk);
        rd_req = !is_wr; wr_req = is_wr; addr = a; byte_en = be; wr_data = wd;
        stall = 0; cnt = 0; wb_seen = 0; fill_seen = 0;
        #1;
        req_at_detect = mem_req_w;
        while (miss_w && stall < 100) begin
            stall++;
            if (mem_req_w) begin
                cnt++;
                if (cnt >= g) begin
                    if (mem_we_w) begin
                        wb_seen++; wb_addr = mem_addr_w; wb_data = mem_wdata_w;
                        mem_model[int'(mem_addr_w)] = mem_wdata_w;
                    end else begin
                        fill_seen++; fill_addr = mem_addr_w;
                        mem_rdata = line_of(int'(mem_addr_w));
                    end
                    mem_gnt = 1'b1; cnt = 0;
                end
            end
            @(negedge clk);
            mem_gnt = 1'b0;
            #1;
        end
        if (miss_w) check("access_timeout", 64'd1, 64'd0);
        rdv = rd_data_w;
        @(negedge clk);
        rd_req = 1'b0; wr_req = 1'b0;
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        clk = 0; rst = 1; sel = 0; rd_req = 0; wr_req = 0; addr = '0; byte_en = '0;
        wr_data = '0; mem_gnt = 0; mem_rdata = '0;
        for (int i = 0; i < 8; i++) ln[i*32 +: 32] = i * 32'h11;
        mem_model[32'h20] = ln;
        ln = make_line(32'h21);
        ln[31:0] = 32'h1122_3344;
        mem_model[32'h21] = ln;
        repeat (3) @(negedge clk);
        rst = 0;
        #1;
        check("rst_miss", miss_w, 0);
        check("rst_mem_req", mem_req_w, 0);
        check("rst_mem_we", mem_we_w, 0);
        check("rst_hit_cnt", hit_cnt_w, 0);
        check("rst_miss_cnt", miss_cnt_w, 0);

        // Cold read miss, clean fill of line 0x20
        access(0, 30'h100, 4'h0, 0, 3);
        check("t1_req_registered", req_at_detect, 0);
        check("t1_fill_addr", fill_addr, 27'h20);
        check("t1_no_wb", wb_seen, 0);
        check("t1_penalty", stall, 5);
        check("t1_rd_word0", rdv, 32'h0);
        check("t1_replay_not_hit", hit_cnt_w, 0);
        access(0, 30'h101, 4'h0, 0, 3);
        check("t1_hit_stall", stall, 0);
        check("t1_rd_word1", rdv, 32'h11);
        check("t1_miss_cnt", miss_cnt_w, 1);
        check("t1_hit_cnt", hit_cnt_w, 1);

        // Byte-enabled store merge
        access(0, 30'h108, 4'h0, 0, 2);
        check("t2_fill_rd", rdv, 32'h1122_3344);
        access(1, 30'h108, 4'b0011, 32'hDEAD_BEEF, 2);
        check("t2_store_stall", stall, 0);
        access(0, 30'h108, 4'h0, 0, 2);
        check("t2_merge", rdv, 32'h1122_BEEF);
        check("t2_merge_stall", stall, 0);
        check("t2_hit_cnt", hit_cnt_w, 3);
        check("t2_miss_cnt", miss_cnt_w, 2);

        // Fill set 2 with tags 0..3, dirty tag 0, then evict it with tag 4
        for (int t = 0; t < 4; t++) access(0, 30'(t * 64 + 16), 4'h0, 0, 1);
        access(1, 30'h10, 4'hF, 32'hCAFE_F00D, 1);
        check("t3_store_hit", stall, 0);
        access(0, 30'h110, 4'h0, 0, 3);
        check("t3_wb_once", wb_seen, 1);
        check("t3_wb_addr", wb_addr, 27'h02);
        check("t3_wb_word0", wb_data[31:0], 32'hCAFE_F00D);
        check("t3_wb_word1", wb_data[63:32], 32'h201);
        check("t3_fill_addr", fill_addr, 27'h22);
        check("t3_dirty_penalty", stall, 8);
        check("t3_rd", rdv, 32'h2200);
        access(0, 30'h10, 4'h0, 0, 1);
        check("t3_tag0_evicted", stall, 3);
        check("t3_tag0_wb_data", rdv, 32'hCAFE_F00D);
        access(0, 30'hD0, 4'h0, 0, 1);
        check("t3_tag3_resident", stall, 0);
        access(0, 30'h50, 4'h0, 0, 1);
        check("t3_tag1_evicted", stall, 3);
        access(0, 30'h90, 4'h0, 0, 1);
        check("t3_tag2_evicted", stall, 3);

        // Clean valid victim with G=5
        access(0, 30'h150, 4'h0, 0, 5);
        check("t4_no_wb", wb_seen, 0);
        check("t4_penalty", stall, 7);
        check("t4_rd", rdv, 32'h2A00);
        check("t4_miss_cnt", miss_cnt_w, 11);
        check("t4_hit_cnt", hit_cnt_w, 5);

        // Reset in the middle of a refill
        @(negedge clk);
        addr = 30'h20; rd_req = 1;
        #1 check("t5_detect", miss_w, 1);
        @(negedge clk);
        #1 check("t5_fill_req", mem_req_w, 1);
        @(negedge clk);
        rst = 1; rd_req = 0;
        @(negedge clk);
        rst = 0; mem_gnt = 1; mem_rdata = make_line(99);
        #1 check("t5_req_dropped", mem_req_w, 0);
        @(negedge clk);
        mem_gnt = 0;
        #1;
        check("t5_gnt_ignored_req", mem_req_w, 0);
        check("t5_gnt_ignored_miss", miss_w, 0);
        check("t5_hit_cnt", hit_cnt_w, 0);
        check("t5_miss_cnt", miss_cnt_w, 0);
        access(0, 30'h101, 4'h0, 0, 1);
        check("t5_lines_invalid", stall, 3);
        check("t5_rd", rdv, 32'h11);
        check("t5_miss_cnt_after", miss_cnt_w, 1);

        // Direct-mapped instance: ping-pong between two tags of set 0
        sel = 1;
        for (int k = 0; k < 6; k++) begin
            access(0, (k % 2) ? 30'h20 : 30'h0, 4'h0, 0, 1);
            check("t6_stall", stall, 3);
            check("t6_rd", rdv, (k % 2) ? 32'h400 : 32'h0);
        end
        check("t6_miss_cnt", miss_cnt_w, 6);
        check("t6_hit_cnt", hit_cnt_w, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
